// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------
// serial_tx : parallel-to-serial UART-style transmitter.
//
// Frame on tx_out : start bit (0), DATA_W data bits LSB first, optional even
// parity bit, stop bit (1). Every line bit is held for CLKS_PER_BIT clocks.
//
// Optional feature macro: SERIAL_TX_PARITY_EN
//   defined   -> a PARITY state follows DATA and sends the XOR of the word
//   undefined -> DATA goes straight to STOP, no parity logic is built
//
// Handshake (valid/ready): a word is accepted on a rising clk edge where
// tx_valid and tx_ready are both 1. tx_valid may be raised at any time and
// should stay high until accepted; tx_data is sampled only at that edge.
// tx_ready is 1 only in IDLE and drops the cycle after acceptance.
//
// rst is asynchronous and active low. tx_out, tx_ready and busy are all
// registered, so there is no combinational path from inputs to outputs.
// ---------------------------------------------------------------------------
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  // Bit timer and bit index widths; both kept at least one bit wide so a
  // single-cycle bit or a single-bit word still gets a legal vector.
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TW-1:0] TMR_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  // FSM encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  logic [2:0]        state_q,  state_d;
  logic [TW-1:0]     timer_q,  timer_d;
  logic [IW-1:0]     idx_q,    idx_d;
  logic [DATA_W-1:0] shreg_q,  shreg_d;
  logic [DATA_W-1:0] shreg_shifted;
  logic              tx_out_d;
  logic              tx_ready_d;
  logic              busy_d;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic accept;
  logic bit_done;

  // Handshake completes only when the transmitter is advertising ready.
  assign accept = tx_valid & tx_ready;

  // Timer terminal count; with CLKS_PER_BIT=1 this is constantly true.
  assign bit_done = (timer_q == TMR_LAST);

  // Shift register contents after the current data bit has been sent.
  assign shreg_shifted = shreg_q >> 1;

  // -------------------------------------------------------------------------
  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so that the registered tx_out already shows the new bit on the first
  // cycle of each state.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    timer_d    = bit_done ? '0 : timer_q + 1'b1;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    tx_out_d   = tx_out;
    tx_ready_d = tx_ready;
    busy_d     = busy;
`ifdef SERIAL_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        timer_d    = '0;
        tx_out_d   = 1'b1;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (accept) begin
          state_d    = S_START;
          shreg_d    = tx_data;
          idx_d      = '0;
          timer_d    = '0;
          tx_out_d   = 1'b0;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
          parity_d   = ^tx_data;
`endif
        end
      end

      S_START: begin
        if (bit_done) begin
          state_d  = S_DATA;
          tx_out_d = shreg_q[0];
        end
      end

      S_DATA: begin
        if (bit_done) begin
          shreg_d = shreg_shifted;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d  = S_PARITY;
            tx_out_d = parity_q;
`else
            state_d  = S_STOP;
            tx_out_d = 1'b1;
`endif
          end else begin
            idx_d    = idx_q + 1'b1;
            tx_out_d = shreg_shifted[0];
          end
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_d  = S_STOP;
          tx_out_d = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (bit_done) begin
          state_d    = S_IDLE;
          timer_d    = '0;
          tx_out_d   = 1'b1;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end

      default: begin
        // Unreachable encodings fall back to a clean idle line.
        state_d    = S_IDLE;
        timer_d    = '0;
        idx_d      = '0;
        tx_out_d   = 1'b1;
        tx_ready_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM, counters and shift register; reset aborts any frame in flight.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Parity of the accepted word, captured alongside the shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Registered outputs. tx_ready stays low out of reset until the first
  // clock edge, so no word can be accepted on the release edge itself.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_out   <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tx_out   <= tx_out_d;
      tx_ready <= tx_ready_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_tx : self-checking bench for serial_tx (DATA_W=8, CLKS_PER_BIT=4).
// Expected line levels are pushed per clock cycle into exp_q when a word is
// offered, and popped and compared against tx_out on each falling edge.
// Build with +define+SERIAL_TX_PARITY_EN to exercise the parity frame.
// ---------------------------------------------------------------------------
module tb_serial_tx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
  localparam int W      = 1;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME  = (DATA_W + 3) * CPB;
`else
  localparam int FRAME  = (DATA_W + 2) * CPB;
`endif

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_out;
  logic              busy;

  logic [W-1:0] exp_q[$];
  int n_tests;
  int n_fail;

  serial_tx #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_out  (tx_out),
    .busy    (busy)
  );

  // -------------------------------------------------------------------------
  // Clock
  // -------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Driver / scoreboard helpers
  // -------------------------------------------------------------------------
  // Queue the per-cycle line levels of one complete frame for word w.
  task automatic push_frame(input logic [DATA_W-1:0] w);
    logic [W-1:0] b;
    for (int k = 0; k < CPB; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) begin
      b = w[i];
      for (int k = 0; k < CPB; k++) exp_q.push_back(b);
    end
`ifdef SERIAL_TX_PARITY_EN
    b = ^w;
    for (int k = 0; k < CPB; k++) exp_q.push_back(b);
`endif
    for (int k = 0; k < CPB; k++) exp_q.push_back(1'b1);
  endtask

  // Offer word w and return once the acceptance edge has passed (+1 time).
  task automatic offer_word(input logic [DATA_W-1:0] w, output bit ok);
    ok = 1'b0;
    tx_data  = w;
    tx_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: tx_ready never 1 for word %h", w);
    end
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset;
    rst      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    #100;
    n_tests++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: tx_out=%b tx_ready=%b busy=%b, want 1 0 0",
               tx_out, tx_ready, busy);
    end
    #50;
    rst = 1'b1;
    #1;
    n_tests++;
    if (tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: tx_ready=%b want 0", tx_ready);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (tx_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset[%0d]: tx_out=%b tx_ready=%b busy=%b, want 1 1 0",
                 i, tx_out, tx_ready, busy);
      end
    end
  endtask

  task automatic test_single_word;
    bit ok;
    logic [W-1:0] e;
    push_frame(8'hA5);
    offer_word(8'hA5, ok);
    tx_valid = 1'b0;
    if (ok) begin
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (tx_out !== e || tx_ready !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL single_a5[%0d]: tx_out=%b tx_ready=%b busy=%b, want %b 0 1",
                   i, tx_out, tx_ready, busy, e);
        end
      end
      @(negedge clk);
      n_tests++;
      if (tx_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL single_end_idle: tx_out=%b tx_ready=%b busy=%b, want 1 1 0",
                 tx_out, tx_ready, busy);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_data_change;
    bit ok;
    logic [W-1:0] e;
    push_frame(8'h3C);
    offer_word(8'h3C, ok);
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
    if (ok) begin
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (tx_out !== e) begin
          n_fail++;
          $display("FAIL data_change_3c[%0d]: tx_out=%b want %b", i, tx_out, e);
        end
      end
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [W-1:0] e;
    push_frame(8'h01);
    exp_q.push_back(1'b1);
    push_frame(8'h80);
    offer_word(8'h01, ok);
    tx_data = 8'h80;
    if (ok) begin
      for (int i = 0; i < 2 * FRAME + 1; i++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (tx_out !== e) begin
          n_fail++;
          $display("FAIL b2b[%0d]: tx_out=%b want %b", i, tx_out, e);
        end
        if (i == FRAME) begin
          n_tests++;
          if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: tx_ready=%b busy=%b want 1 0", tx_ready, busy);
          end
          @(posedge clk);
          #1;
          tx_valid = 1'b0;
        end
      end
    end
    tx_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mid_reset;
    bit ok;
    logic [W-1:0] e;
    push_frame(8'hA5);
    offer_word(8'hA5, ok);
    tx_valid = 1'b0;
    if (ok) begin
      // Cycles 16..19 carry data bit 3 of 0xA5 (a 0).
      for (int i = 0; i < 18; i++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (tx_out !== e) begin
          n_fail++;
          $display("FAIL pre_reset_a5[%0d]: tx_out=%b want %b", i, tx_out, e);
        end
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if (tx_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset: tx_out=%b busy=%b tx_ready=%b, want 1 0 0",
                 tx_out, busy, tx_ready);
      end
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: tx_out=%b tx_ready=%b busy=%b, want 1 1 0",
               tx_out, tx_ready, busy);
    end
    push_frame(8'h55);
    offer_word(8'h55, ok);
    tx_valid = 1'b0;
    if (ok) begin
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (tx_out !== e) begin
          n_fail++;
          $display("FAIL after_reset_55[%0d]: tx_out=%b want %b", i, tx_out, e);
        end
      end
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random_words;
    bit ok;
    logic [W-1:0] e;
    logic [DATA_W-1:0] w;
    for (int n = 0; n < 4; n++) begin
      w = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      push_frame(w);
      offer_word(w, ok);
      tx_valid = 1'b0;
      if (ok) begin
        for (int i = 0; i < FRAME; i++) begin
          @(negedge clk);
          e = exp_q.pop_front();
          n_tests++;
          if (tx_out !== e) begin
            n_fail++;
            $display("FAIL random_%h[%0d]: tx_out=%b want %b", w, i, tx_out, e);
          end
        end
      end
      exp_q.delete();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity;
    bit ok;
    logic [DATA_W-1:0] words [2];
    logic              par   [2];
    words[0] = 8'hA5; par[0] = 1'b0;
    words[1] = 8'h07; par[1] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      offer_word(words[n], ok);
      tx_valid = 1'b0;
      if (ok) begin
        // Parity bit occupies cycles (1+DATA_W)*CPB .. +CPB-1 of the frame.
        for (int i = 0; i < 44; i++) begin
          @(negedge clk);
          if (i >= 36 && i < 40) begin
            n_tests++;
            if (tx_out !== par[n]) begin
              n_fail++;
              $display("FAIL parity_%h[%0d]: tx_out=%b want %b",
                       words[n], i, tx_out, par[n]);
            end
          end
          if (i == 43) begin
            n_tests++;
            if (busy !== 1'b1 || tx_out !== 1'b1) begin
              n_fail++;
              $display("FAIL parity_len_last_%h: busy=%b tx_out=%b want 1 1",
                       words[n], busy, tx_out);
            end
          end
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || tx_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL parity_len_end_%h: busy=%b tx_ready=%b want 0 1",
                   words[n], busy, tx_ready);
        end
      end
    end
  endtask
`endif

  // -------------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single_word();
    test_data_change();
    test_back_to_back();
    test_mid_reset();
    test_random_words();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-to-serial transmitter, UART-style frame: start bit, DATA_W data bits LSB first, stop bit.
- Drives a single-bit line `tx_out` to be sampled by a downstream flipflop/receiver chain.
- Upstream sources words through a valid/ready handshake.
- Each line bit is held for CLKS_PER_BIT clock cycles.

Parameters:
- DATA_W, 8, data bits per frame (1..16)
- CLKS_PER_BIT, 4, clock cycles per line bit (>=1); bit-timer width is $clog2(CLKS_PER_BIT), minimum 1

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- tx_data  input  DATA_W  word to send; sampled only at acceptance
- tx_valid  input  1  upstream has a word
- tx_ready  output  1  transmitter can accept a word
- tx_out  output  1  serial line, idle high
- busy  output  1  frame in progress (any state except IDLE)

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - state=IDLE, tx_out=1, tx_ready=0, busy=0, shift register and counters cleared.
  - tx_ready rises at the first clk edge after rst deasserts.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - tx_out=1, tx_ready=1.
  - Acceptance = rising edge with tx_valid=1 and tx_ready=1.
  - At acceptance: tx_data latched into the shift register, bit timer=0, bit index=0, go to START.
- Signals after acceptance:
  - tx_ready=0 from the cycle after acceptance until the frame ends.
  - tx_data and tx_valid are ignored while not in IDLE; later changes do not affect the frame.
- START: tx_out=0 for CLKS_PER_BIT cycles.
- DATA:
  - tx_out = shift register bit 0.
  - After CLKS_PER_BIT cycles, shift right, bit index+1.
  - After DATA_W bits, go to PARITY if enabled, else STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles, then IDLE.
- Latency:
  - tx_out falls on the first cycle after the acceptance edge.
  - Frame length = (DATA_W+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity.
- Spacing: minimum one IDLE cycle between frames; tx_ready returns to 1 on the first IDLE cycle after STOP.
- Registers: tx_out, tx_ready and busy are registered outputs; no combinational path from input to output.
- tx_valid=1 held continuously: words are sent back-to-back with exactly one idle-high cycle between frames.
- Reset mid-frame: frame aborted, tx_out=1 immediately; no partial frame resumes after reset.
- CLKS_PER_BIT=1: one cycle per bit; the timer is always at terminal count.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA.
  - tx_out = even parity bit (XOR of the latched word) for CLKS_PER_BIT cycles.
  - Frame length = (DATA_W+3)*CLKS_PER_BIT.
- Undefined:
  - No PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan (DATA_W=8, CLKS_PER_BIT=4):
- Reset then idle: rst=0 for 150 time units, release, tx_valid=0 for 10 cycles -> tx_out=1, busy=0, tx_ready=1 from the first edge after release.
- Single word: send 0xA5 -> tx_out sequence per 4 cycles: 0 (start), 1,0,1,0,0,1,0,1, 1 (stop); 40 cycles total; tx_ready=0 throughout, busy=1.
- Data change after acceptance: send 0x3C, then drive tx_data=0xFF in the next cycle -> serialized bits are still 0,0,1,1,1,1,0,0.
- Back-to-back: tx_valid held 1 with 0x01 then 0x80 -> two correct frames separated by exactly 1 idle cycle of tx_out=1.
- Mid-frame reset: assert rst=0 during data bit 3 of 0xA5 -> tx_out=1 immediately, busy=0; after release the next accepted word 0x55 is sent cleanly.
- With SERIAL_TX_PARITY_EN:
  - 0xA5 -> parity bit 0, frame 44 cycles.
  - 0x07 -> parity bit 1.
